fsm_seq_tx: RTL and testbench
=============================

# fsm_seq_tx

Moore-style serial sequence transmitter: captures a parallel bit pattern on a start request and drives it onto the single-bit line `X`, MSB first. Each bit is held until a bit-rate `tick` is seen. After the last bit, the line is held low for a fixed gap and a one-cycle `done` pulse is issued. It is the stimulus/transmit end for the lab's serial sequence-detector FSMs, which consume `X`.

## Interface
Parameters:
- `WIDTH`, default 8: maximum pattern length in bits (≥1).
- `GAP`, default 2: number of ticks `X` is held low after the last bit (≥0).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to transmit; sampled only in IDLE.
- `pattern`  in  WIDTH  bits to send; `pattern[len-1]` is sent first.
- `len`  in  $clog2(WIDTH+1)  number of bits to send.
- `tick`  in  1  bit-rate enable; one bit period ends per sampled `tick`=1.
- `X`  out  1  serial output.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of transmission.

## Operation
- States: IDLE, SEND, GAP, DONE. Outputs are Moore (a function of registered state/datapath only); no combinational path from any input to any output.
- IDLE: `X`=0, `busy`=0, `done`=0.
  - `start`=1 with `len`≠0: load `shreg` = `pattern << (WIDTH - len_eff)`, `cnt` = `len_eff`; go to SEND.
  - `len_eff` = min(`len`, WIDTH); `len` > WIDTH is clamped.
  - `start`=1 with `len`=0: ignored; stay IDLE, no `done`.
- SEND: `X` = `shreg[WIDTH-1]`, `busy`=1.
  - On `tick`=1: shift `shreg` left by 1, zero-fill, `cnt`--.
  - On `tick`=1 with `cnt`=1: go to GAP, loading `gcnt`=GAP; if GAP=0, go directly to DONE.
- GAP: `X`=0, `busy`=1. On `tick`=1: `gcnt`--; when `gcnt`=1 and `tick`=1, go to DONE.
- DONE: `X`=0, `busy`=1, `done`=1 for exactly one cycle, then IDLE unconditionally. `tick` is ignored.
- `start` outside IDLE (including DONE) is ignored and not queued.
- `pattern`/`len` changes after capture have no effect on the frame in progress.
- `tick` in IDLE/DONE has no effect.
- Illegal state encoding: next state IDLE, outputs as IDLE.

## Timing
- Reset (asynchronous, `reset`=0): immediately state=IDLE, `X`=0, `busy`=0, `done`=0, `shreg`=0, `cnt`=0, `gcnt`=0. The frame in progress is discarded; no `done`.
- Reset release: the first rising edge with `reset`=1 may accept `start`.
- Latency with `start` sampled at edge k:
  - SEND from cycle k+1; `X` shows the first bit in cycle k+1.
  - `busy` rises in cycle k+1.
- With `tick` tied to 1:
  - bits occupy cycles k+1 … k+len;
  - gap occupies k+len+1 … k+len+GAP;
  - `done` is high in cycle k+len+GAP+1;
  - IDLE from k+len+GAP+2.
  - Next `start` is accepted at edge k+len+GAP+2 at the earliest.
- Bit period = number of cycles from state/bit entry up to and including the first cycle with `tick`=1. Consecutive ticks on back-to-back cycles give 1-cycle bits.
- `len`=WIDTH: full pattern sent, no shift alignment.
- `len`=1: one bit, then gap.
- Counters: `cnt` is $clog2(WIDTH+1) bits; `gcnt` is $clog2(GAP+1) bits (min 1). Neither ever wraps below zero.

## Test plan
- Reset, then WIDTH=8, GAP=2, `tick`=1, `pattern`=8'b1011_0010, `len`=8, one-cycle `start` -> `X` = 1,0,1,1,0,0,1,0 on cycles k+1..k+8; 0,0 on k+9..k+10; `done`=1 only at k+11; `busy`=1 over k+1..k+11; IDLE at k+12.
- `pattern`=8'hFF, `len`=3, `tick` high every 4th cycle -> `X`=1 for 3 bit periods of 4 cycles each, then 0 for 2 ticks, then a single `done` pulse. Upper pattern bits are never transmitted.
- `len`=0 with `start`=1; then `len`=12 (clamped to 8) with `pattern`=8'h81 -> first request: `busy` stays 0, no `done`; second: `X` = 1,0,0,0,0,0,0,1.
- During SEND: `start` pulsed and `pattern` changed mid-frame -> frame bits unchanged, exactly one `done`, no second frame.
- `reset` asserted asynchronously (between clock edges) mid-SEND -> `X`, `busy`, `done` go 0 before the next edge; after release, `busy`=0 until a new `start`.
- GAP=0, `len`=2, `pattern`=2'b01, `tick`=1 -> `X` = 0,1 on k+1..k+2; `done` at k+3; IDLE at k+4.

Source files
------------

// File: rtl/fsm_seq_tx_if.sv
// rtl/fsm_seq_tx_if.sv - request/serial-line bundle for fsm_seq_tx
// Ports: start/pattern/len/tick (requester -> transmitter),
//        X/busy/done (transmitter -> requester).
// master: requester side; slave: transmitter side.
interface fsm_seq_tx_if #(
  parameter int WIDTH = 8
) ();
  localparam int LW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    len;
  logic             tick;
  logic             X;
  logic             busy;
  logic             done;

  modport master (output start, pattern, len, tick, input X, busy, done);
  modport slave  (input start, pattern, len, tick, output X, busy, done);
endinterface

// File: rtl/fsm_seq_tx.sv
// rtl/fsm_seq_tx.sv - Moore serial sequence transmitter, MSB first, tick-paced
// Ports: clk (rising edge), reset (async, active-low),
//        bus.start/pattern/len/tick in, bus.X/busy/done out (all registered).
module fsm_seq_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic         clk,
  input  logic         reset,
  fsm_seq_tx_if.slave  bus
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [LW-1:0] WMAX = LW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [LW-1:0]    cnt;
  logic [GW-1:0]    gcnt;
  logic             x_q, busy_q, done_q;

  logic [LW-1:0]    len_eff;
  logic [WIDTH-1:0] loaded;
  logic [WIDTH-1:0] shifted;

  // Left-align the captured pattern so the first bit always sits at the MSB.
  always_comb begin
    len_eff = (bus.len > WMAX) ? WMAX : bus.len;
    loaded  = bus.pattern << (WMAX - len_eff);
    shifted = shreg << 1;
  end

  // Outputs are assigned alongside the state they belong to, so they are
  // registered and always reflect the state entered on this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      shreg  <= '0;
      cnt    <= '0;
      gcnt   <= '0;
      x_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          x_q    <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start && (bus.len != '0)) begin
            shreg  <= loaded;
            cnt    <= len_eff;
            state  <= S_SEND;
            busy_q <= 1'b1;
            x_q    <= loaded[WIDTH-1];
          end
        end
        S_SEND: begin
          if (bus.tick) begin
            shreg <= shifted;
            if (cnt != '0) cnt <= cnt - LW'(1);
            if (cnt == LW'(1)) begin
              x_q <= 1'b0;
              if (GAP == 0) begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end else begin
                state <= S_GAP;
                gcnt  <= GW'(GAP);
              end
            end else begin
              x_q <= shifted[WIDTH-1];
            end
          end
        end
        S_GAP: begin
          if (bus.tick) begin
            if (gcnt != '0) gcnt <= gcnt - GW'(1);
            if (gcnt == GW'(1)) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          x_q    <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          x_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.X    = x_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_fsm_seq_tx.sv
// tb/tb_fsm_seq_tx.sv - directed self-checking bench for fsm_seq_tx
module tb_fsm_seq_tx;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fsm_seq_tx_if #(.WIDTH(8)) bus ();
  fsm_seq_tx_if #(.WIDTH(8)) bus0 ();

  fsm_seq_tx #(.WIDTH(8), .GAP(2)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  fsm_seq_tx #(.WIDTH(8), .GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 0; bus.pattern = '0; bus.len = '0; bus.tick = 0;
    bus0.start = 0; bus0.pattern = '0; bus0.len = '0; bus0.tick = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.X !== 1'b0) begin n_fail++; $display("FAIL reset_x got %b want 0", bus.X); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Full-width frame with tick tied high; c is the cycle index after start edge k.
  task automatic test_basic();
    logic [7:0] exp_pat;
    exp_pat = 8'b1011_0010;
    bus.tick = 1; bus.pattern = exp_pat; bus.len = 4'd8; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    for (int c = 1; c <= 12; c++) begin
      n_checks++; if (bus.X !== ((c <= 8) ? exp_pat[8-c] : 1'b0)) begin n_fail++; $display("FAIL basic_x c=%0d got %b", c, bus.X); end
      n_checks++; if (bus.busy !== (c <= 11)) begin n_fail++; $display("FAIL basic_busy c=%0d got %b want %b", c, bus.busy, c <= 11); end
      n_checks++; if (bus.done !== (c == 11)) begin n_fail++; $display("FAIL basic_done c=%0d got %b want %b", c, bus.done, c == 11); end
      @(negedge clk);
    end
  endtask

  // tick on every 4th cycle: bits on c=1..12, gap c=13..20, done at 21.
  task automatic test_slow_tick();
    bus.tick = 0; bus.pattern = 8'hFF; bus.len = 4'd3; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    for (int c = 1; c <= 23; c++) begin
      bus.tick = ((c % 4) == 0);
      n_checks++; if (bus.X !== (c <= 12)) begin n_fail++; $display("FAIL slow_x c=%0d got %b want %b", c, bus.X, c <= 12); end
      n_checks++; if (bus.busy !== (c <= 21)) begin n_fail++; $display("FAIL slow_busy c=%0d got %b want %b", c, bus.busy, c <= 21); end
      n_checks++; if (bus.done !== (c == 21)) begin n_fail++; $display("FAIL slow_done c=%0d got %b want %b", c, bus.done, c == 21); end
      @(negedge clk);
    end
    bus.tick = 1;
  endtask

  task automatic test_len_zero_clamp();
    logic [7:0] exp_pat;
    exp_pat = 8'h81;
    bus.tick = 1; bus.pattern = 8'hFF; bus.len = 4'd0; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    for (int c = 1; c <= 3; c++) begin
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy c=%0d got %b want 0", c, bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL len0_done c=%0d got %b want 0", c, bus.done); end
      @(negedge clk);
    end
    bus.pattern = exp_pat; bus.len = 4'd12; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    for (int c = 1; c <= 12; c++) begin
      n_checks++; if (bus.X !== ((c <= 8) ? exp_pat[8-c] : 1'b0)) begin n_fail++; $display("FAIL clamp_x c=%0d got %b", c, bus.X); end
      n_checks++; if (bus.done !== (c == 11)) begin n_fail++; $display("FAIL clamp_done c=%0d got %b want %b", c, bus.done, c == 11); end
      @(negedge clk);
    end
  endtask

  // start re-asserted mid-SEND and in DONE, pattern/len changed mid-frame.
  task automatic test_back_to_back();
    logic [7:0] exp_pat;
    int         dones;
    exp_pat = 8'b1011_0010;
    dones = 0;
    bus.tick = 1; bus.pattern = exp_pat; bus.len = 4'd8; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin bus.start = 1; bus.pattern = 8'h00; bus.len = 4'd1; end
      if (c == 4) bus.start = 0;
      if (c == 11) bus.start = 1;
      if (c == 12) bus.start = 0;
      if (bus.done === 1'b1) dones++;
      n_checks++; if (bus.X !== ((c <= 8) ? exp_pat[8-c] : 1'b0)) begin n_fail++; $display("FAIL midframe_x c=%0d got %b", c, bus.X); end
      n_checks++; if (bus.busy !== (c <= 11)) begin n_fail++; $display("FAIL midframe_busy c=%0d got %b want %b", c, bus.busy, c <= 11); end
      @(negedge clk);
    end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL midframe_done_count got %0d want 1", dones); end
  endtask

  task automatic test_async_reset();
    bus.tick = 1; bus.pattern = 8'b1011_0010; bus.len = 4'd8; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    @(negedge clk);
    @(negedge clk);
    // cycle k+3: bit pattern[5] = 1
    n_checks++; if (bus.X !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL areset_pre got X=%b busy=%b want 1/1", bus.X, bus.busy); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.X !== 1'b0) begin n_fail++; $display("FAIL areset_x got %b want 0", bus.X); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL areset_done got %b want 0", bus.done); end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL areset_after c=%0d got busy=%b done=%b want 0/0", c, bus.busy, bus.done); end
    end
  endtask

  task automatic test_gap_zero();
    bus0.tick = 1; bus0.pattern = 8'b0000_0001; bus0.len = 4'd2; bus0.start = 1;
    @(negedge clk);
    bus0.start = 0;
    for (int c = 1; c <= 5; c++) begin
      n_checks++; if (bus0.X !== (c == 2)) begin n_fail++; $display("FAIL gap0_x c=%0d got %b want %b", c, bus0.X, c == 2); end
      n_checks++; if (bus0.busy !== (c <= 3)) begin n_fail++; $display("FAIL gap0_busy c=%0d got %b want %b", c, bus0.busy, c <= 3); end
      n_checks++; if (bus0.done !== (c == 3)) begin n_fail++; $display("FAIL gap0_done c=%0d got %b want %b", c, bus0.done, c == 3); end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_slow_tick();
    test_len_zero_clamp();
    test_back_to_back();
    test_async_reset();
    test_gap_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
